// File: rtl/mips_bus_pkg.sv
// ----------------------------------------------------------------------------
// mips_bus_pkg : shared types for the CPU-to-bus bridges.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/bus_watchdog.sv
// ----------------------------------------------------------------------------
// bus_watchdog : saturating wait counter, expired at TIMEOUT_CYCLES-1.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int             c_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_WIDTH-1:0] c_LAST = c_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [c_WIDTH-1:0] r_count;

  // Holds at the terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en && (r_count != c_LAST)) begin
      r_count <= r_count + c_WIDTH'(1);
    end
  end

  assign expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/mips_data_bus_bridge.sv
// ----------------------------------------------------------------------------
// mips_data_bus_bridge : CPU data port to waitrequest bus, with stall,
// watchdog and protocol error flags.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mips_data_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_stall,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        err_timeout,
  output logic        err_proto
);

  bridge_state_t r_state;
  bridge_state_t w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_is_read;
  logic        r_err_timeout;
  logic        r_err_proto;

  logic w_req;
  logic w_busy;
  logic w_stall;
  logic w_expired;
  logic w_wd_clear;
  logic w_wd_count;

  assign w_req  = cpu_read | cpu_write;
  assign w_busy = (r_state == BUSY);

  assign w_wd_count = w_busy & avm_waitrequest;
  assign w_wd_clear = ~w_busy | ~avm_waitrequest | w_expired;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_wd_clear),
    .count_en(w_wd_count),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_req;
        if (w_req) begin
          w_next = BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (!avm_waitrequest || w_expired) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // A simultaneous read+write is flagged and then carried out as a read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_is_read     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_proto   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr    <= {cpu_address[31:2], 2'b00};
            r_wdata   <= cpu_writedata;
            r_is_read <= cpu_read;
            if ((cpu_read && cpu_write) || (cpu_address[1:0] != 2'b00)) begin
              r_err_proto <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!avm_waitrequest) begin
            if (r_is_read) begin
              r_rdata <= avm_readdata;
            end
          end else if (w_expired) begin
            if (r_is_read) begin
              r_rdata <= TIMEOUT_DATA;
            end
            r_err_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign avm_read       = w_busy & r_is_read;
  assign avm_write      = w_busy & ~r_is_read;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = (avm_read | avm_write) ? BYTEEN_ALL : 4'b0000;

  // Stall must never freeze the CPU while the system is held in reset.
  assign cpu_stall    = reset ? w_stall : 1'b0;
  assign cpu_readdata = r_rdata;
  assign err_timeout  = r_err_timeout;
  assign err_proto    = r_err_proto;

endmodule

`default_nettype wire

// File: tb/tb_mips_data_bus_bridge.sv
// ----------------------------------------------------------------------------
// tb_mips_data_bus_bridge : directed self-checking bench for the data bridge.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mips_data_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        err_timeout;
  logic        err_proto;

  int n_cmp  = 0;
  int n_fail = 0;

  mips_data_bus_bridge #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA  (32'hDEADBEEF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_address    (cpu_address),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_writedata  (cpu_writedata),
    .cpu_readdata   (cpu_readdata),
    .cpu_stall      (cpu_stall),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .err_timeout    (err_timeout),
    .err_proto      (err_proto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one CPU access from IDLE up to the DONE cycle, acting as the bus.
  task automatic run_access(input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_addr, input int waits,
                            input logic [31:0] rdata,
                            output int stall_cyc, output int strobe_cyc,
                            output logic stable_ok, output logic saw_write);
    logic done;
    cpu_read      = rd;
    cpu_write     = wr;
    cpu_address   = addr;
    cpu_writedata = wdata;
    stall_cyc  = 0;
    strobe_cyc = 0;
    stable_ok  = 1'b1;
    saw_write  = 1'b0;
    done       = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (avm_read || avm_write) begin
        strobe_cyc++;
        avm_waitrequest = (strobe_cyc <= waits);
        avm_readdata    = rdata;
        if (avm_address !== exp_addr || avm_byteenable !== 4'hF ||
            (avm_write && avm_writedata !== wdata))
          stable_ok = 1'b0;
        if (avm_write) saw_write = 1'b1;
      end else begin
        avm_waitrequest = 1'b0;
      end
      #1;
      if (cpu_stall) begin
        stall_cyc++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) chk("access_bound", 32'd0, 32'd1);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  int   s_cyc, b_cyc;
  logic ok, sw;

  initial begin
    reset = 1'b0;
    cpu_address = '0; cpu_read = 1'b1; cpu_write = 1'b0; cpu_writedata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    step(); step();
    chk("rst_stall", cpu_stall, 0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_readdata", cpu_readdata, 32'h0);
    chk("rst_address", avm_address, 32'h0);
    chk("rst_be", avm_byteenable, 4'h0);
    chk("rst_errs", {err_timeout, err_proto}, 0);
    cpu_read = 1'b0;
    reset = 1'b1;
    step();

    // 1: zero-wait read
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 0, 32'h12345678, s_cyc, b_cyc, ok, sw);
    chk("t1_stall_cycles", s_cyc, 2);
    chk("t1_strobe_cycles", b_cyc, 1);
    chk("t1_stable", ok, 1);
    chk("t1_readdata", cpu_readdata, 32'h12345678);
    chk("t1_done_avm_read", avm_read, 0);
    chk("t1_errs", {err_timeout, err_proto}, 0);
    step();

    // 2: write with 5 wait cycles
    run_access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h20, 5, 32'h0, s_cyc, b_cyc, ok, sw);
    chk("t2_stall_cycles", s_cyc, 7);
    chk("t2_strobe_cycles", b_cyc, 6);
    chk("t2_stable", ok, 1);
    chk("t2_saw_write", sw, 1);
    chk("t2_readdata_kept", cpu_readdata, 32'h12345678);
    chk("t2_errs", {err_timeout, err_proto}, 0);
    step();

    // 3: hung read abandoned by the watchdog
    run_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h40, 1000, 32'h55555555, s_cyc, b_cyc, ok, sw);
    chk("t3_strobe_cycles", b_cyc, 8);
    chk("t3_stall_cycles", s_cyc, 9);
    chk("t3_readdata", cpu_readdata, 32'hDEADBEEF);
    chk("t3_err_timeout", err_timeout, 1);
    chk("t3_err_proto", err_proto, 0);
    avm_waitrequest = 1'b0;
    step();
    chk("t3_sticky", err_timeout, 1);

    // 4: read+write together at a misaligned address
    run_access(1'b1, 1'b1, 32'h13, 32'h77777777, 32'h10, 0, 32'hA5A50000, s_cyc, b_cyc, ok, sw);
    chk("t4_err_proto", err_proto, 1);
    chk("t4_aligned_addr", ok, 1);
    chk("t4_no_write", sw, 0);
    chk("t4_readdata", cpu_readdata, 32'hA5A50000);
    step();

    // 6: back-to-back zero-wait loads
    cpu_read = 1'b1; cpu_address = 32'h100; avm_waitrequest = 1'b0; avm_readdata = 32'h11112222;
    #1;
    chk("t6_idle_stall", cpu_stall, 1);
    step();
    chk("t6_busy1_read", avm_read, 1);
    step();
    chk("t6_done1_stall", cpu_stall, 0);
    chk("t6_done1_read", avm_read, 0);
    chk("t6_done1_data", cpu_readdata, 32'h11112222);
    cpu_address = 32'h104; avm_readdata = 32'h33334444;
    step();
    chk("t6_idle2_read", avm_read, 0);
    chk("t6_idle2_stall", cpu_stall, 1);
    step();
    chk("t6_busy2_read", avm_read, 1);
    chk("t6_busy2_addr", avm_address, 32'h104);
    step();
    chk("t6_done2_data", cpu_readdata, 32'h33334444);
    chk("t6_done2_stall", cpu_stall, 0);
    cpu_read = 1'b0;
    step();

    // 5: reset during the third BUSY cycle of a stalled write
    cpu_write = 1'b1; cpu_address = 32'h30; cpu_writedata = 32'h0BADF00D; avm_waitrequest = 1'b1;
    step(); step(); step();
    chk("t5_busy3_write", avm_write, 1);
    reset = 1'b0;
    step();
    chk("t5_rst_write", avm_write, 0);
    chk("t5_rst_stall", cpu_stall, 0);
    chk("t5_rst_errs", {err_timeout, err_proto}, 0);
    chk("t5_rst_addr", avm_address, 32'h0);
    cpu_write = 1'b0; avm_waitrequest = 1'b0;
    reset = 1'b1;
    step();
    chk("t5_idle_stall", cpu_stall, 0);
    chk("t5_idle_write", avm_write, 0);
    cpu_read = 1'b1; cpu_address = 32'h50;
    #1;
    chk("t5_new_req_stall", cpu_stall, 1);
    step();
    chk("t5_new_req_read", avm_read, 1);
    cpu_read = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
